// File: rtl/mult32_shift_add_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encodings, operand width and step-counter width.
package mult32_shift_add_pkg;

    localparam int MULT_W     = 32;
    localparam int MULT_CNT_W = 5;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_CALC = 2'd1,
        MULT_FIN  = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult32_shift_add_step.sv
// One shift-and-add step: conditionally add the multiplicand, then shift it left by one.
module mult_step #(
    parameter int PW = 64
) (
    input  logic [PW-1:0] acc,
    input  logic [PW-1:0] mcand,
    input  logic          mplier_lsb,
    output logic [PW-1:0] next_acc,
    output logic [PW-1:0] next_mcand
);

    assign next_acc   = mplier_lsb ? (acc + mcand) : acc;
    assign next_mcand = {mcand[PW-2:0], 1'b0};

endmodule

// File: rtl/mult32_shift_add.sv
// Sequential WIDTHxWIDTH multiplier, one multiplier bit per cycle, START/READY/DONE handshake.
// Define MULT_SIGNED_EN to honour SGN (magnitude multiply plus final two's-complement fix-up).
module mult32_shift_add
    import mult32_shift_add_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SGN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             READY,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int PW = 2 * WIDTH;

    mult_state_e           state, state_nxt;
    logic [MULT_CNT_W-1:0] count;
    logic [PW-1:0]         acc;
    logic [PW-1:0]         mcand;
    logic [WIDTH-1:0]      mplier;
    logic [WIDTH-1:0]      hi_q;
    logic [WIDTH-1:0]      lo_q;

    logic [PW-1:0]         step_acc;
    logic [PW-1:0]         step_mcand;
    logic [PW-1:0]         result;
    logic [WIDTH-1:0]      a_mag;
    logic [WIDTH-1:0]      b_mag;
    logic                  last_step;

    assign last_step = (count == MULT_CNT_W'(WIDTH - 1));

    mult_step #(.PW(PW)) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier_lsb (mplier[0]),
        .next_acc   (step_acc),
        .next_mcand (step_mcand)
    );

`ifdef MULT_SIGNED_EN
    logic neg_q;
    logic neg_in;

    // Magnitude of the most negative value wraps to itself, which is correct unsigned.
    always_comb begin
        a_mag  = (SGN && A[WIDTH-1]) ? (-A) : A;
        b_mag  = (SGN && B[WIDTH-1]) ? (-B) : B;
        neg_in = SGN & (A[WIDTH-1] ^ B[WIDTH-1]);
        result = neg_q ? (-step_acc) : step_acc;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            neg_q <= 1'b0;
        else if (state == MULT_IDLE && START)
            neg_q <= neg_in;
    end
`else
    always_comb begin
        a_mag  = A;
        b_mag  = B;
        result = step_acc;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= MULT_IDLE;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                MULT_IDLE: begin
                    if (START) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                MULT_CALC: begin
                    acc    <= step_acc;
                    mcand  <= step_mcand;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    // Result registers only move on the final step, so they hold through FIN/IDLE.
                    if (last_step) begin
                        hi_q <= result[PW-1:WIDTH];
                        lo_q <= result[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        READY     = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            MULT_IDLE: begin
                READY = 1'b1;
                if (START)
                    state_nxt = MULT_CALC;
            end
            MULT_CALC: begin
                BUSY = 1'b1;
                if (last_step)
                    state_nxt = MULT_FIN;
            end
            MULT_FIN: begin
                DONE      = 1'b1;
                state_nxt = MULT_IDLE;
            end
            default: state_nxt = MULT_IDLE;
        endcase
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_mult32_shift_add.sv
// Scoreboard bench for mult32_shift_add: accepts are observed and modelled with plain
// 64-bit arithmetic; a monitor pops expectations on every DONE.
module tb_mult32_shift_add;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        SGN;
    logic [31:0] A;
    logic [31:0] B;
    logic        READY;
    logic        BUSY;
    logic        DONE;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;
    logic [63:0] exp_q[$];
    int edge_q[$];

    mult32_shift_add dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .SGN   (SGN),
        .A     (A),
        .B     (B),
        .READY (READY),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ae;
        logic [63:0] be;
        ae = {32'b0, a};
        be = {32'b0, b};
`ifdef MULT_SIGNED_EN
        if (s) begin
            ae = {{32{a[31]}}, a};
            be = {{32{b[31]}}, b};
        end
`else
        if (s) ae = {32'b0, a};
`endif
        return ae * be;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, reflecting what the next rising edge will see.
    always @(negedge CLK) begin
        logic [63:0] e;
        int ed;
        if (RST) begin
            exp_q.delete();
            edge_q.delete();
        end else begin
            if (DONE) begin
                done_cnt++;
                chk("done_single_cycle", {63'b0, prev_done}, 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e  = exp_q.pop_front();
                    ed = edge_q.pop_front();
                    chk("product", {HI, LO}, e);
                    chk("latency", 64'(cyc - ed), 64'd32);
                end
            end
            if (READY && START) begin
                exp_q.push_back(model(A, B, SGN));
                edge_q.push_back(cyc + 1);
            end
        end
        prev_done = DONE;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!READY && n < 100) begin
            tick();
            n++;
        end
        if (!READY) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 200) begin
            tick();
            n++;
        end
        if (done_cnt < target) chk("done_timeout", 64'(done_cnt), 64'(target));
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        wait_ready();
        A = a; B = b; SGN = s; START = 1'b1;
        tick();
        START = 1'b0;
        A = $urandom; B = $urandom; SGN = 1'($urandom);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s);
        int t;
        t = done_cnt + 1;
        issue(a, b, s);
        wait_done(t);
        chk("ready_after_done", {63'b0, READY}, 64'd1);
        chk("result_hold", {HI, LO}, model(a, b, s));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        RST = 1'b1; START = 1'b0; SGN = 1'b0; A = '0; B = '0;
        tick(); tick();
        RST = 1'b0;
        chk("reset_ready", {63'b0, READY}, 64'd1);
        chk("reset_busy",  {63'b0, BUSY},  64'd0);
        chk("reset_done",  {63'b0, DONE},  64'd0);
        chk("reset_hilo",  {HI, LO},       64'd0);

        run(32'd5, 32'd7, 1'b0);
        chk("5x7", {HI, LO}, 64'h0000_0000_0000_0023);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("max_unsigned", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
        run(32'hFFFF_FFFE, 32'd3, 1'b1);
        run(32'h8000_0000, 32'h8000_0000, 1'b1);
        run(32'd0, 32'h1234_5678, 1'b1);

        // START held high: exactly one accept per IDLE visit.
        wait_ready();
        A = 32'd2; B = 32'd3; SGN = 1'b0; START = 1'b1;
        t = done_cnt + 2;
        tick();
        A = 32'd4; B = 32'd4;
        wait_done(t);
        START = 1'b0;
        chk("held_start_second", {HI, LO}, 64'd16);

        // Reset on the 10th CALC edge discards the operation.
        wait_ready();
        A = 32'h1234_5678; B = 32'h9ABC_DEF0; SGN = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (9) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("midreset_ready", {63'b0, READY}, 64'd1);
        chk("midreset_busy",  {63'b0, BUSY},  64'd0);
        chk("midreset_done",  {63'b0, DONE},  64'd0);
        chk("midreset_hilo",  {HI, LO},       64'd0);
        run(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        chk("fresh_after_reset", {HI, LO}, 64'h0B00_EA4E_242D_2080);

        // Reset and START on the same edge: request dropped.
        wait_ready();
        RST = 1'b1; START = 1'b1; A = 32'd9; B = 32'd9;
        tick();
        RST = 1'b0; START = 1'b0;
        chk("rst_start_ready", {63'b0, READY}, 64'd1);
        tick();
        chk("rst_start_busy",  {63'b0, BUSY},  64'd0);
        chk("rst_start_hilo",  {HI, LO},       64'd0);

        for (int i = 0; i < 20; i++)
            run($urandom, $urandom, 1'($urandom));

        repeat (3) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
